// File: rtl/cnt_seq_pkg.sv
// rtl/cnt_seq_pkg.sv - shared types and widths for the counter sequencer
package cnt_seq_pkg;

   // Counter value / start width, segment length width, completed-segment counter width
   localparam int CNT_W = 8;
   localparam int LEN_W = 8;
   localparam int SEG_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // One segment command as accepted from the host
   typedef struct packed {
      logic [CNT_W-1:0] start;
      logic [LEN_W-1:0] len;
      logic             dir;
   } cmd_t;

endpackage

// File: rtl/cnt_seq_cmd_slot.sv
// rtl/cnt_seq_cmd_slot.sv - one-entry pending command register with valid bit
module cnt_seq_cmd_slot
   import cnt_seq_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic fill_i,
   input  logic drain_i,
   input  logic flush_i,
   input  cmd_t data_i,
   output logic valid_o,
   output cmd_t data_o
);

   logic valid_q, valid_d;
   cmd_t data_q, data_d;

   // Slot register; flush has priority so an abort always empties it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // Next slot contents: flush > fill > drain
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (fill_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/cnt_seq_ctrl.sv
// rtl/cnt_seq_ctrl.sv - segment sequencer driving counter load/enable/dir; CNT_SEQ_PREFETCH_EN adds a pending-command slot
module cnt_seq_ctrl
   import cnt_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_start,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_dir,
   input  logic             hold,
   input  logic             abort,
   output logic             cnt_load,
   output logic [CNT_W-1:0] cnt_load_val,
   output logic             cnt_en,
   output logic             cnt_dir,
   output logic             busy,
   output logic             done,
   output logic [SEG_W-1:0] seg_cnt
);

   state_t           state_q, state_d;
   cmd_t             cur_q, cur_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [SEG_W-1:0] seg_q, seg_d;

   cmd_t             cmd_in;
   logic             xfer;

   assign cmd_in = '{start: cmd_start, len: cmd_len, dir: cmd_dir};
   assign xfer   = cmd_valid && cmd_ready;

`ifdef CNT_SEQ_PREFETCH_EN
   logic slot_valid;
   cmd_t slot_data;
   logic slot_fill;
   logic slot_drain;

   // A transfer while LOAD/RUN is parked in the slot; in DONE it bypasses straight to LOAD
   assign slot_fill  = xfer && ((state_q == LOAD) || (state_q == RUN));
   assign slot_drain = (state_q == DONE) && slot_valid && !abort;

   cnt_seq_cmd_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .fill_i  (slot_fill),
      .drain_i (slot_drain),
      .flush_i (abort),
      .data_i  (cmd_in),
      .valid_o (slot_valid),
      .data_o  (slot_data)
   );

   assign cmd_ready = !abort && ((state_q == IDLE) || !slot_valid);
`else
   assign cmd_ready = !abort && (state_q == IDLE);
`endif

   // State, latched command, remaining enabled cycles and completed-segment count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cur_q   <= '0;
         rem_q   <= '0;
         seg_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         rem_q   <= rem_d;
         seg_q   <= seg_d;
      end
   end

   // Next-state: abort overrides everything; hold only freezes RUN
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rem_d   = rem_q;
      seg_d   = seg_q;
      if (abort) begin
         state_d = IDLE;
         rem_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  cur_d   = cmd_in;
                  state_d = LOAD;
               end
            end
            LOAD: begin
               rem_d   = cur_q.len;
               state_d = (cur_q.len == '0) ? DONE : RUN;
            end
            RUN: begin
               if (!hold) begin
                  rem_d = rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               seg_d   = seg_q + SEG_W'(1);
               state_d = IDLE;
`ifdef CNT_SEQ_PREFETCH_EN
               if (slot_valid) begin
                  cur_d   = slot_data;
                  state_d = LOAD;
               end else if (xfer) begin
                  cur_d   = cmd_in;
                  state_d = LOAD;
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Counter controls decode the registered state; only cnt_en sees hold/abort directly
   assign cnt_load     = (state_q == LOAD);
   assign cnt_load_val = (state_q == LOAD) ? cur_q.start : '0;
   assign cnt_dir      = ((state_q == LOAD) || (state_q == RUN)) ? cur_q.dir : 1'b0;
   assign cnt_en       = (state_q == RUN) && !hold && !abort;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign seg_cnt      = seg_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb/tb_cnt_seq_ctrl.sv - self-checking bench for cnt_seq_ctrl
module tb_cnt_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_start = 8'h00;
   logic [7:0] cmd_len = 8'h00;
   logic       cmd_dir = 1'b0;
   logic       hold = 1'b0;
   logic       abort = 1'b0;
   logic       cnt_load;
   logic [7:0] cnt_load_val;
   logic       cnt_en;
   logic       cnt_dir;
   logic       busy;
   logic       done;
   logic [7:0] seg_cnt;

   int n_assert = 0;
   int n_fail = 0;

`ifdef CNT_SEQ_PREFETCH_EN
   localparam logic PF = 1'b1;
`else
   localparam logic PF = 1'b0;
`endif

   cnt_seq_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_start    (cmd_start),
      .cmd_len      (cmd_len),
      .cmd_dir      (cmd_dir),
      .hold         (hold),
      .abort        (abort),
      .cnt_load     (cnt_load),
      .cnt_load_val (cnt_load_val),
      .cnt_en       (cnt_en),
      .cnt_dir      (cnt_dir),
      .busy         (busy),
      .done         (done),
      .seg_cnt      (seg_cnt)
   );

   always #5 clk = ~clk;

   // Attached counter datapath plus event tallies
   logic [7:0] ctr;
   int         en_total;
   int         done_total;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr        <= 8'h00;
         en_total   <= 0;
         done_total <= 0;
      end else begin
         if (cnt_load)    ctr <= cnt_load_val;
         else if (cnt_en) ctr <= cnt_dir ? ctr - 8'd1 : ctr + 8'd1;
         if (cnt_en) en_total   <= en_total + 1;
         if (done)   done_total <= done_total + 1;
      end
   end

   logic [7:0] exp_seg = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete segment from IDLE; hold is high on offsets hf..hf+hl-1 after the transfer
   task automatic run_seg(input logic [7:0] s, input logic [7:0] l, input logic d,
                          input int hf, input int hl);
      int         ens;
      int         k;
      int         lim;
      int         en0;
      int         done0;
      logic       fin;
      logic       hnow;
      logic [7:0] exp_ctr;
      ens = 0; fin = 1'b0;
      en0 = en_total; done0 = done_total;
      lim = int'(l) + hl + 8;
      exp_ctr = d ? s - l : s + l;
      cmd_valid = 1'b1; cmd_start = s; cmd_len = l; cmd_dir = d; hold = 1'b0; abort = 1'b0;
      #1;
      chk("idle_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      tick();
      cmd_valid = 1'b0; cmd_start = 8'($urandom); cmd_len = 8'($urandom); cmd_dir = 1'($urandom);
      k = 1;
      while (!fin && k < lim) begin
         hnow = (k >= hf) && (k < hf + hl);
         hold = hnow;
         #1;
         chk("seg_busy", busy, 1);
         chk("seg_ready", cmd_ready, PF);
         if (k == 1) begin
            chk("load", cnt_load, 1);
            chk("load_val", cnt_load_val, s);
            chk("load_en", cnt_en, 0);
            chk("load_dir", cnt_dir, d);
            chk("load_done", done, 0);
         end else if (ens < int'(l)) begin
            chk("run_load", cnt_load, 0);
            chk("run_en", cnt_en, !hnow);
            chk("run_dir", cnt_dir, d);
            chk("run_done", done, 0);
            if (!hnow) ens++;
         end else begin
            chk("done_pulse", done, 1);
            chk("done_en", cnt_en, 0);
            fin = 1'b1;
         end
         tick();
         k++;
      end
      if (!fin) chk("seg_timeout", 0, 1);
      hold = 1'b0;
      #1;
      exp_seg = exp_seg + 8'd1;
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
      chk("post_seg", seg_cnt, exp_seg);
      chk("post_ctr", ctr, exp_ctr);
      chk("post_en_cycles", en_total - en0, l);
      chk("post_done_cnt", done_total - done0, 1);
   endtask

   initial begin
      logic [7:0] seg_before;
      int         en0;
      int         done0;

      // Reset state while rst_n is low
      #2;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_load", cnt_load, 0);
      chk("rst_en", cnt_en, 0);
      chk("rst_dir", cnt_dir, 0);
      chk("rst_val", cnt_load_val, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_seg", seg_cnt, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rel_busy", busy, 0);
      chk("rel_ready", cmd_ready, 1);

      // Directed segments: basic up, down through zero, zero length, hold mid-RUN, max length
      run_seg(8'h10, 8'd3, 1'b0, 0, 0);
      run_seg(8'h01, 8'd3, 1'b1, 0, 0);
      run_seg(8'h55, 8'd0, 1'b0, 0, 0);
      run_seg(8'h30, 8'd4, 1'b0, 3, 2);
      run_seg(8'hF0, 8'd255, 1'b0, 7, 3);

      // Abort in RUN with two enabled cycles left, hold also high to show abort wins
      en0 = en_total; done0 = done_total; seg_before = seg_cnt;
      cmd_valid = 1'b1; cmd_start = 8'h40; cmd_len = 8'd5; cmd_dir = 1'b0;
      #1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick(); tick(); tick();
      hold = 1'b1; abort = 1'b1;
      #1;
      chk("abort_en", cnt_en, 0);
      chk("abort_ready", cmd_ready, 0);
      chk("abort_done", done, 0);
      tick();
      hold = 1'b0; abort = 1'b0;
      #1;
      chk("abort_idle", busy, 0);
      chk("abort_ready_after", cmd_ready, 1);
      tick(); tick();
      chk("abort_no_done", done_total - done0, 0);
      chk("abort_seg", seg_cnt, seg_before);
      chk("abort_ctr", ctr, 8'h43);
      chk("abort_en_cycles", en_total - en0, 3);

      // Second command offered during RUN of the first
      en0 = en_total;
      cmd_valid = 1'b1; cmd_start = 8'h20; cmd_len = 8'd3; cmd_dir = 1'b0;
      #1;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("b2b_a_en1", cnt_en, 1);
      cmd_valid = 1'b1; cmd_start = 8'h80; cmd_len = 8'd2; cmd_dir = 1'b1;
      #1;
      chk("b2b_ready_run", cmd_ready, PF);
      tick();
      if (PF) cmd_valid = 1'b0;
      #1;
      chk("b2b_ready_full", cmd_ready, 0);
      chk("b2b_a_en2", cnt_en, 1);
      tick();
      chk("b2b_a_en3", cnt_en, 1);
      chk("b2b_ready_full2", cmd_ready, 0);
      tick();
      chk("b2b_a_done", done, 1);
      chk("b2b_ready_done", cmd_ready, 0);
      exp_seg = exp_seg + 8'd1;
      tick();
      if (!PF) begin
         chk("b2b_idle_gap", busy, 0);
         chk("b2b_idle_ready", cmd_ready, 1);
         tick();
         cmd_valid = 1'b0;
         #1;
      end
      chk("b2b_b_load", cnt_load, 1);
      chk("b2b_b_val", cnt_load_val, 8'h80);
      chk("b2b_b_busy", busy, 1);
      tick();
      chk("b2b_b_en1", cnt_en, 1);
      chk("b2b_b_dir", cnt_dir, 1);
      tick();
      chk("b2b_b_en2", cnt_en, 1);
      tick();
      chk("b2b_b_done", done, 1);
      exp_seg = exp_seg + 8'd1;
      tick();
      chk("b2b_end_busy", busy, 0);
      chk("b2b_seg", seg_cnt, exp_seg);
      chk("b2b_ctr", ctr, 8'h7E);
      chk("b2b_en_cycles", en_total - en0, 5);

      // Randomised segments with random hold windows
      for (int i = 0; i < 12; i++) begin
         run_seg(8'($urandom), 8'($urandom_range(0, 12)), 1'($urandom),
                 $urandom_range(1, 6), $urandom_range(0, 3));
      end

      // Enough zero-length segments to wrap seg_cnt
      for (int i = 0; i < 245; i++) begin
         run_seg(8'($urandom), 8'd0, 1'($urandom), 0, 0);
      end

      // Asynchronous reset in the middle of a segment
      cmd_valid = 1'b1; cmd_start = 8'h11; cmd_len = 8'd6; cmd_dir = 1'b0;
      #1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick();
      chk("mid_en", cnt_en, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_en", cnt_en, 0);
      chk("arst_ready", cmd_ready, 1);
      chk("arst_seg", seg_cnt, 0);
      chk("arst_done", done, 0);
      tick();
      rst_n = 1'b1;
      exp_seg = 8'h00;
      tick();
      run_seg(8'hA0, 8'd2, 1'b1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
Command-driven sequencer for the 8-bit loadable up/down counter. Accepts segment commands (start value, length, direction) over a valid/ready handshake and drives the counter's load/enable/direction controls. Each segment loads the start value, then enables counting for exactly `len` cycles. Sits between the host/config logic and the counter datapath, replacing direct pin control of load/enable/dir.

Parameters:
- CNT_W, 8, width of counter value and cmd_start.
- LEN_W, 8, width of segment length and the internal remaining-cycle counter.
- SEG_W, 8, width of the completed-segment counter seg_cnt.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller accepts the command this cycle.
- cmd_start  in  CNT_W  value loaded into the counter.
- cmd_len  in  LEN_W  number of enabled count cycles.
- cmd_dir  in  1  count direction: 0 = up, 1 = down.
- hold  in  1  pause counting; no effect on state while held.
- abort  in  1  synchronous abort of the current and any pending command.
- cnt_load  out  1  to counter: load cnt_load_val.
- cnt_load_val  out  CNT_W  to counter: load value.
- cnt_en  out  1  to counter: count enable.
- cnt_dir  out  1  to counter: direction.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a segment completes normally.
- seg_cnt  out  SEG_W  count of completed segments; wraps modulo 2^SEG_W.

Behaviour:
- Reset values:
  - state = IDLE; cmd_ready = 1; cnt_load = 0; cnt_en = 0; cnt_dir = 0; cnt_load_val = 0.
  - busy = 0; done = 0; seg_cnt = 0; remaining = 0.
- Handshake: transfer occurs when cmd_valid && cmd_ready. cmd_ready is forced to 0 while abort = 1.
- All counter-control outputs are registered state decodes, except cnt_en, which is additionally gated combinationally by !hold && !abort.
- States:
  - IDLE: cmd_ready = 1. On transfer, latch start/len/dir and go to LOAD.
  - LOAD (1 cycle): cnt_load = 1, cnt_load_val = start, cnt_en = 0, cnt_dir = latched dir; remaining <= len. If len == 0, go to DONE; else go to RUN.
  - RUN: cnt_en = !hold, cnt_dir = latched dir. Each cycle with cnt_en = 1, remaining decrements. When remaining == 1 and cnt_en = 1, go to DONE. Exactly len enabled cycles per segment; hold cycles do not count.
  - DONE (1 cycle): done = 1, seg_cnt increments, cnt_en = 0. Next state is IDLE (or LOAD, see Optional Feature).
- Latency: transfer at cycle T → cnt_load at T+1 → first cnt_en at T+2 (if no hold) → done at T+2+len.
- Counter value wrap-around (255→0, 0→255) belongs to the counter; the controller ignores it. len = 255 is legal; len = 0 gives LOAD then DONE with no enabled cycles.
- abort (any state): next state IDLE; cnt_en = 0 in the abort cycle; no done pulse; seg_cnt unchanged; pending command discarded. abort during LOAD still lets that load take effect.
- hold during LOAD or DONE has no effect. hold and abort together: abort wins.
- cmd_valid deasserted mid-segment: no effect.
- Reset mid-segment: all outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro: CNT_SEQ_PREFETCH_EN.
- With the macro defined:
  - One-entry pending-command slot. cmd_ready = 1 in IDLE, or in LOAD/RUN/DONE when the slot is empty.
  - Transfer outside IDLE fills the slot.
  - DONE with slot full goes directly to LOAD of the pending command (no IDLE cycle) and empties the slot.
  - busy stays 1 across back-to-back segments.
- Without the macro: cmd_ready = 1 only in IDLE; DONE always goes to IDLE.

Decomposition:
- Package cnt_seq_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE};
  - packed struct cmd_t {start, len, dir};
  - localparam widths.
- Sub-module cnt_seq_cmd_slot: one-entry register with valid bit, fill/drain/flush. Used only under CNT_SEQ_PREFETCH_EN.

Test Plan:
- Reset, then cmd start = 8'h10, len = 3, dir = 0 → cnt_load at T+1 with value 8'h10; cnt_en high T+2..T+4; done at T+5; seg_cnt = 1; busy low at T+6.
- start = 8'h01, len = 3, dir = 1 → cnt_dir = 1 throughout RUN; attached counter reads 8'hFE after done (wrap through 0).
- len = 0 → LOAD then DONE; cnt_en never asserted; done pulses; seg_cnt increments.
- len = 4 with hold high for 2 cycles mid-RUN → exactly 4 enabled cycles; done delayed by 2 cycles.
- abort asserted during RUN with remaining = 2 → cnt_en low that cycle; IDLE next cycle; no done; seg_cnt unchanged; cmd_ready = 0 while abort is high.
- Prefetch build: second cmd sent during RUN of the first → slot fills, cmd_ready drops; DONE is followed directly by LOAD; busy never drops. Non-prefetch build: cmd_ready stays 0 until IDLE.
